regs_wb_arbiter: RTL and testbench
==================================

REGS_WB_ARBITER -- requirements
Module: regs_wb_arbiter

Interface
REQ-001 Parameter: ADDR_W, 5, register address width (32 architectural registers).
REQ-002 Parameter: DATA_W, 32, register data width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_  input  1  asynchronous, active-high reset (1 = in reset).
REQ-005 a_valid_i  input  1  requester A (ALU writeback) write request.
REQ-006 a_ready_o  output  1  requester A request accepted this cycle when high with a_valid_i.
REQ-007 a_addr_i  input  ADDR_W  requester A destination register.
REQ-008 a_data_i  input  DATA_W  requester A write data.
REQ-009 b_valid_i, b_ready_o, b_addr_i, b_data_i  as REQ-005..008 for requester B (load unit).
REQ-010 we_o  output  1  write enable to register file, registered.
REQ-011 waddr_o  output  ADDR_W  write address to register file, registered.
REQ-012 wdata_o  output  DATA_W  write data to register file, registered.
REQ-013 pend_o  output  32  per-register pending-write mask.

Function
REQ-014 Each requester SHALL own one holding entry (valid, addr, data); handshake completes on a rising edge with valid_i and ready_o both high.
REQ-015 x_ready_o SHALL equal (!hold_x_valid | grant_x); no combinational path from any *_valid_i to any *_ready_o.
REQ-016 An accepted request with addr 0 SHALL complete the handshake but SHALL NOT load the holding entry (x0 writes dropped, no we_o).
REQ-017 Grant: one holding entry only valid -> grant it; both valid -> grant port selected by rr_ptr; none -> no grant.
REQ-018 rr_ptr SHALL update only on a grant, to point at the non-granted port.
REQ-019 On grant, next edge SHALL set we_o=1, waddr_o/wdata_o = granted entry, and clear that entry unless refilled in the same cycle (REQ-015).
REQ-020 No grant -> we_o=0 next cycle; waddr_o/wdata_o SHALL hold last values.
REQ-021 Latency: handshake at edge N -> we_o high for exactly one cycle after edge N+1 when uncontended; sustained single-port throughput one write per cycle.
REQ-022 Both ports same address in the same cycle: both SHALL be written on consecutive cycles in grant order; last written value wins.
REQ-023 pend_o[k] SHALL be 1 iff a valid holding entry has addr k or (we_o=1 and waddr_o=k); pend_o[0] SHALL always be 0.
REQ-024 At most one we_o pulse per cycle; no accepted nonzero-address request SHALL be lost or duplicated.

Reset
REQ-025 While rst_=1: holding entries invalid, we_o=0, waddr_o=0, wdata_o=0, pend_o=0, rr_ptr=A, a_ready_o=b_ready_o=0.
REQ-026 Reset asserted mid-operation SHALL discard holding entries and any in-flight write immediately (asynchronously).
REQ-027 First handshake possible at the first rising edge after rst_ falls.

Configuration
REQ-028 Macro REGS_WB_FIXED_PRIO_EN defined: REQ-017 both-valid case SHALL always grant A, rr_ptr unused.
REQ-029 Macro REGS_WB_FIXED_PRIO_EN undefined: round-robin per REQ-017/018.

Verification
REQ-030 Reset then A writes addr 1 data 0x42 -> we_o=1, waddr_o=1, wdata_o=0x42 one cycle after edge N+1; pend_o[1]=1 until that write cycle ends.
REQ-031 A and B valid every cycle, addrs 2/3, round-robin -> we_o every cycle alternating A,B,A,B starting with A; with REGS_WB_FIXED_PRIO_EN -> B ready low while A streams.
REQ-032 A writes addr 0 data 0xDEADBEEF -> a_ready_o handshake completes, we_o stays 0, pend_o=0.
REQ-033 A addr 31 data 0x1, B addr 31 data 0x2 same edge, rr_ptr=A -> we_o writes 0x1 then 0x2 on consecutive cycles.
REQ-034 rst_ pulsed while both entries valid -> we_o=0, pend_o=0 immediately; no write issued after release.

Source files
------------

// File: rtl/regs_wb_arbiter.sv
`timescale 1ns/1ps
// Register-file writeback arbiter: two requesters (A=ALU, B=load) each own
// one holding entry; a round-robin grant feeds registered we/waddr/wdata.
// Ports: clk, rst_ (async active-high), a_/b_ valid/ready/addr/data,
//        we_o/waddr_o/wdata_o (registered), pend_o (pending-write mask).
// Macro REGS_WB_FIXED_PRIO_EN: when both entries are valid, A always wins.
module regs_wb_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              a_valid_i,
  output logic              a_ready_o,
  input  logic [ADDR_W-1:0] a_addr_i,
  input  logic [DATA_W-1:0] a_data_i,
  input  logic              b_valid_i,
  output logic              b_ready_o,
  input  logic [ADDR_W-1:0] b_addr_i,
  input  logic [DATA_W-1:0] b_data_i,
  output logic              we_o,
  output logic [ADDR_W-1:0] waddr_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic [31:0]       pend_o
);

  logic              hold_a_valid;
  logic [ADDR_W-1:0] hold_a_addr;
  logic [DATA_W-1:0] hold_a_data;
  logic              hold_b_valid;
  logic [ADDR_W-1:0] hold_b_addr;
  logic [DATA_W-1:0] hold_b_data;

  logic grant_a;
  logic grant_b;
  logic a_acc;
  logic b_acc;

`ifdef REGS_WB_FIXED_PRIO_EN
  assign grant_a = hold_a_valid;
`else
  typedef enum logic {PORT_A, PORT_B} port_e;
  port_e rr_ptr;

  assign grant_a = hold_a_valid
                 & (!hold_b_valid | (rr_ptr == PORT_A));

  // Pointer moves only on a grant, to the port that lost.
  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      rr_ptr <= PORT_A;
    end else if (grant_a) begin
      rr_ptr <= PORT_B;
    end else if (hold_b_valid) begin
      rr_ptr <= PORT_A;
    end
  end
`endif

  assign grant_b = hold_b_valid & !grant_a;

  // Ready depends only on state (and reset), never on valid_i.
  assign a_ready_o = !rst_ & (!hold_a_valid | grant_a);
  assign b_ready_o = !rst_ & (!hold_b_valid | grant_b);

  assign a_acc = a_valid_i & a_ready_o;
  assign b_acc = b_valid_i & b_ready_o;

  // x0 writes complete the handshake but never occupy the entry;
  // a refill in the grant cycle takes priority over the clear.
  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      hold_a_valid <= 1'b0;
      hold_a_addr  <= '0;
      hold_a_data  <= '0;
    end else if (a_acc && (a_addr_i != '0)) begin
      hold_a_valid <= 1'b1;
      hold_a_addr  <= a_addr_i;
      hold_a_data  <= a_data_i;
    end else if (grant_a) begin
      hold_a_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      hold_b_valid <= 1'b0;
      hold_b_addr  <= '0;
      hold_b_data  <= '0;
    end else if (b_acc && (b_addr_i != '0)) begin
      hold_b_valid <= 1'b1;
      hold_b_addr  <= b_addr_i;
      hold_b_data  <= b_data_i;
    end else if (grant_b) begin
      hold_b_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      we_o    <= 1'b0;
      waddr_o <= '0;
      wdata_o <= '0;
    end else if (grant_a) begin
      we_o    <= 1'b1;
      waddr_o <= hold_a_addr;
      wdata_o <= hold_a_data;
    end else if (grant_b) begin
      we_o    <= 1'b1;
      waddr_o <= hold_b_addr;
      wdata_o <= hold_b_data;
    end else begin
      we_o    <= 1'b0;
    end
  end

  always_comb begin
    pend_o = '0;
    for (int k = 1; k < 32; k++) begin
      pend_o[k] = (hold_a_valid && (hold_a_addr == ADDR_W'(k)))
                | (hold_b_valid && (hold_b_addr == ADDR_W'(k)))
                | (we_o && (waddr_o == ADDR_W'(k)));
    end
  end

endmodule

// File: tb/tb_regs_wb_arbiter.sv
`timescale 1ns/1ps
// Bench for regs_wb_arbiter: vector table plus hand sequences,
// with a write scoreboard popped on every we_o pulse.
module tb_regs_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_;
  logic        a_valid_i, b_valid_i;
  logic        a_ready_o, b_ready_o;
  logic [4:0]  a_addr_i, b_addr_i;
  logic [31:0] a_data_i, b_data_i;
  logic        we_o;
  logic [4:0]  waddr_o;
  logic [31:0] wdata_o;
  logic [31:0] pend_o;

  regs_wb_arbiter #(.ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .rst_(rst_),
    .a_valid_i(a_valid_i), .a_ready_o(a_ready_o),
    .a_addr_i(a_addr_i), .a_data_i(a_data_i),
    .b_valid_i(b_valid_i), .b_ready_o(b_ready_o),
    .b_addr_i(b_addr_i), .b_data_i(b_data_i),
    .we_o(we_o), .waddr_o(waddr_o), .wdata_o(wdata_o),
    .pend_o(pend_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic        av;
    logic [4:0]  aa;
    logic [31:0] ad;
    logic        bv;
    logic [4:0]  ba;
    logic [31:0] bd;
    int          n;
    logic [4:0]  e0a;
    logic [31:0] e0d;
    logic [4:0]  e1a;
    logic [31:0] e1d;
    logic [31:0] pend;
  } vec_t;

  wr_t  sb[$];
  vec_t vt[10];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit stream_on = 0;
  int s_wr = 0;
  int s_first = 0;
  int s_last = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Write monitor: every we_o pulse must match the next expected write.
  always @(negedge clk) begin
    wr_t e;
    cyc++;
    if (!rst_ && we_o) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write actual=%0d/%h expected=none",
                 waddr_o, wdata_o);
      end else begin
        e = sb.pop_front();
        if (waddr_o !== e.addr || wdata_o !== e.data) begin
          errors++;
          $display("FAIL wb_write actual=%0d/%h expected=%0d/%h",
                   waddr_o, wdata_o, e.addr, e.data);
        end
      end
      if (stream_on) begin
        if (s_wr == 0) s_first = cyc;
        s_last = cyc;
        s_wr++;
      end
    end
  end

  function automatic wr_t mk(logic [4:0] a, logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    return w;
  endfunction

  task automatic idle_inputs();
    a_valid_i = 0; a_addr_i = '0; a_data_i = '0;
    b_valid_i = 0; b_addr_i = '0; b_data_i = '0;
  endtask

  initial begin
    int ka, kb, guard;
    bit ahs, bhs;
    // rr pointer order is tracked by hand: after the A-only
    // sequence below it points at B.
    vt[0] = '{0,0,0, 1,5,32'h55, 1, 5,32'h55, 0,0, 32'h20};
    vt[1] = '{1,0,32'hDEADBEEF, 0,0,0, 0, 0,0, 0,0, 32'h0};
    vt[2] = '{1,31,32'h1, 1,31,32'h2, 2, 31,32'h1, 31,32'h2,
              32'h8000_0000};
    vt[3] = '{1,7,32'h70, 1,9,32'h90, 2, 7,32'h70, 9,32'h90,
              32'h280};
    vt[4] = '{0,0,0, 1,4,32'hB4, 1, 4,32'hB4, 0,0, 32'h10};
    vt[5] = '{1,10,32'hA, 1,0,32'hBB, 1, 10,32'hA, 0,0, 32'h400};
    vt[6] = '{1,12,32'hC1, 1,13,32'hD1, 2, 13,32'hD1, 12,32'hC1,
              32'h3000};
    vt[7] = '{1,0,32'h5, 1,0,32'h6, 0, 0,0, 0,0, 32'h0};
    vt[8] = '{1,20,32'hA20, 1,20,32'hB20, 2, 20,32'hB20, 20,32'hA20,
              32'h0010_0000};
    vt[9] = '{1,1,32'h11, 1,2,32'h22, 2, 2,32'h22, 1,32'h11,
              32'h6};

    rst_ = 1;
    idle_inputs();
    repeat (2) @(negedge clk);
    chk("rst_we", {31'b0, we_o}, 0);
    chk("rst_waddr", {27'b0, waddr_o}, 0);
    chk("rst_wdata", wdata_o, 0);
    chk("rst_pend", pend_o, 0);
    chk("rst_ready", {30'b0, a_ready_o, b_ready_o}, 0);
    rst_ = 0;

    // Single A write: latency and pend window.
    @(negedge clk);
    a_valid_i = 1; a_addr_i = 1; a_data_i = 32'h42;
    sb.push_back(mk(1, 32'h42));
    @(posedge clk); #1;
    idle_inputs();
    chk("lat_n_we", {31'b0, we_o}, 0);
    chk("lat_n_pend", pend_o, 32'h2);
    @(posedge clk); #1;
    chk("lat_n1_we", {31'b0, we_o}, 1);
    chk("lat_n1_waddr", {27'b0, waddr_o}, 1);
    chk("lat_n1_wdata", wdata_o, 32'h42);
    chk("lat_n1_pend", pend_o, 32'h2);
    @(posedge clk); #1;
    chk("lat_n2_we", {31'b0, we_o}, 0);
    chk("lat_n2_pend", pend_o, 0);
    chk("lat_hold_wdata", wdata_o, 32'h42);

    foreach (vt[i]) begin
      @(negedge clk);
      a_valid_i = vt[i].av; a_addr_i = vt[i].aa; a_data_i = vt[i].ad;
      b_valid_i = vt[i].bv; b_addr_i = vt[i].ba; b_data_i = vt[i].bd;
      if (vt[i].n > 0) sb.push_back(mk(vt[i].e0a, vt[i].e0d));
      if (vt[i].n > 1) sb.push_back(mk(vt[i].e1a, vt[i].e1d));
      #1;
      chk($sformatf("vec%0d_ready", i),
          {30'b0, a_ready_o, b_ready_o}, 32'h3);
      @(posedge clk); #1;
      idle_inputs();
      chk($sformatf("vec%0d_pend", i), pend_o, vt[i].pend);
      repeat (4) @(posedge clk);
      #1;
      chk($sformatf("vec%0d_drain", i), sb.size(), 0);
      chk($sformatf("vec%0d_pend_end", i), pend_o, 0);
    end

    // Reset while both entries are valid and a write is in flight.
    @(negedge clk);
    a_valid_i = 1; a_addr_i = 6; a_data_i = 32'h66;
    b_valid_i = 1; b_addr_i = 8; b_data_i = 32'h88;
    @(posedge clk); #1;
    idle_inputs();
    @(posedge clk); #1;
    chk("mid_we_before", {31'b0, we_o}, 1);
    chk("mid_pend_before", pend_o, 32'h140);
    #1 rst_ = 1;
    #1;
    chk("mid_we", {31'b0, we_o}, 0);
    chk("mid_pend", pend_o, 0);
    chk("mid_ready", {30'b0, a_ready_o, b_ready_o}, 0);
    chk("mid_waddr", {27'b0, waddr_o}, 0);
    @(negedge clk);
    rst_ = 0;
    repeat (5) @(posedge clk);
    #1;
    chk("mid_pend_after", pend_o, 0);
    chk("mid_we_after", {31'b0, we_o}, 0);

    // Both ports streaming: writes A,B,A,B with no gaps.
    for (int i = 0; i < 6; i++) begin
      sb.push_back(mk(2, 32'h100 + i));
      sb.push_back(mk(3, 32'h200 + i));
    end
    stream_on = 1;
    ka = 0; kb = 0; guard = 0;
    while ((ka < 6 || kb < 6) && guard < 100) begin
      @(negedge clk);
      a_valid_i = (ka < 6); a_addr_i = 2; a_data_i = 32'h100 + ka;
      b_valid_i = (kb < 6); b_addr_i = 3; b_data_i = 32'h200 + kb;
      #1;
      ahs = a_valid_i && a_ready_o;
      bhs = b_valid_i && b_ready_o;
      @(posedge clk);
      if (ahs) ka++;
      if (bhs) kb++;
      guard++;
    end
    #1 idle_inputs();
    chk("stream_timeout", {31'b0, guard < 100}, 1);
    repeat (5) @(posedge clk);
    #1;
    stream_on = 0;
    chk("stream_drain", sb.size(), 0);
    chk("stream_count", s_wr, 12);
    chk("stream_gapless", s_last - s_first + 1, 12);
    chk("stream_pend", pend_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
